// File: rtl/alu_const_pkg.sv
// Shared constants for the ALU port-A constant operand generator:
// default table contents, select index names and table geometry.
package alu_const_pkg;

    localparam int unsigned LOW_W_DEF   = 8;
    localparam int unsigned NUM_SEL_DEF = 16;

    localparam int unsigned SEL_1  = 0;
    localparam int unsigned SEL_8  = 1;
    localparam int unsigned SEL_10 = 2;
    localparam int unsigned SEL_18 = 3;
    localparam int unsigned SEL_20 = 4;
    localparam int unsigned SEL_28 = 5;
    localparam int unsigned SEL_30 = 6;
    localparam int unsigned SEL_38 = 7;
    localparam int unsigned SEL_66 = 8;
    localparam int unsigned SEL_AA = 9;
    localparam int unsigned SEL_06 = 10;
    localparam int unsigned SEL_60 = 11;
    localparam int unsigned SEL_02 = 12;
    localparam int unsigned SEL_04 = 13;
    localparam int unsigned SEL_40 = 14;
    localparam int unsigned SEL_80 = 15;

    // Entry 0 sits in the least significant byte.
    localparam logic [8*NUM_SEL_DEF-1:0] DEF_TABLE = {
        8'h80, 8'h40, 8'h04, 8'h02, 8'h60, 8'h06, 8'hAA, 8'h66,
        8'h38, 8'h30, 8'h28, 8'h20, 8'h18, 8'h10, 8'h08, 8'h01
    };

    function automatic logic [7:0] def_entry(input int unsigned idx);
        if (idx < NUM_SEL_DEF) begin
            return DEF_TABLE[idx*8 +: 8];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/alu_const_table.sv
// Runtime-writable constant table with async-reset defaults and an
// OR-reduced read across all selected entries.
module alu_const_table
    import alu_const_pkg::*;
#(
    parameter int unsigned LOW_W   = LOW_W_DEF,
    parameter int unsigned NUM_SEL = NUM_SEL_DEF,
    parameter int unsigned ADDR_W  = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [LOW_W-1:0]   i_data,
    input  logic [NUM_SEL-1:0] i_sel,
    output logic [LOW_W-1:0]   o_data
);

    logic [LOW_W-1:0] r_tab [NUM_SEL];
    logic [LOW_W-1:0] w_or;

    // Addresses at or beyond NUM_SEL never match an entry, so they are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SEL; i++) begin
                r_tab[i] <= LOW_W'(def_entry(i));
            end
        end else if (i_we) begin
            for (int unsigned i = 0; i < NUM_SEL; i++) begin
                if (i_addr == ADDR_W'(i)) begin
                    r_tab[i] <= i_data;
                end
            end
        end
    end

    always_comb begin
        w_or = '0;
        for (int unsigned i = 0; i < NUM_SEL; i++) begin
            if (i_sel[i]) begin
                w_or = w_or | r_tab[i];
            end
        end
    end

    assign o_data = w_or;

endmodule

// File: rtl/alu_const_operand_gen.sv
// Registered constant-operand generator for ALU port A: table lookup,
// optional upper fill, flags and a valid/ready output register.
module alu_const_operand_gen
    import alu_const_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LOW_W   = LOW_W_DEF,
    parameter int unsigned NUM_SEL = NUM_SEL_DEF,
    parameter int unsigned ERR_W   = 8,
    localparam int unsigned ADDR_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NUM_SEL-1:0] req_sel,
    input  logic               req_fill,
    input  logic               req_high,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_high,
    output logic               out_multi,
    output logic               out_zero,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [LOW_W-1:0]   cfg_data,
    output logic [ERR_W-1:0]   err_cnt
);

    generate
        if (LOW_W > WIDTH || NUM_SEL < 1) begin : g_bad_params
            $error("alu_const_operand_gen: need LOW_W <= WIDTH and NUM_SEL >= 1");
        end
    endgenerate

    // Bits above the table constant; empty when WIDTH == LOW_W.
    localparam logic [WIDTH-1:0] HI_MASK = ~WIDTH'({LOW_W{1'b1}});

    logic [LOW_W-1:0] w_low;
    logic [WIDTH-1:0] w_next_data;
    logic             w_accept;
    logic             w_multi;
    logic             w_zero;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_high;
    logic             r_multi;
    logic             r_zero;
    logic [ERR_W-1:0] r_err;

    alu_const_table #(
        .LOW_W   (LOW_W),
        .NUM_SEL (NUM_SEL),
        .ADDR_W  (ADDR_W)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .i_we   (cfg_we),
        .i_addr (cfg_addr),
        .i_data (cfg_data),
        .i_sel  (req_sel),
        .o_data (w_low)
    );

    assign req_ready   = !r_valid || out_ready;
    assign w_accept    = req_valid && req_ready;
    assign w_multi     = ($countones(req_sel) > 1);
    assign w_zero      = (req_sel == '0);
    assign w_next_data = WIDTH'(w_low) | ({WIDTH{req_fill}} & HI_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_high  <= 1'b0;
            r_multi <= 1'b0;
            r_zero  <= 1'b0;
            r_err   <= '0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= w_next_data;
                r_high  <= req_high;
                r_multi <= w_multi;
                r_zero  <= w_zero;
                if (w_multi && (r_err != '1)) begin
                    r_err <= r_err + 1'b1;
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_high  = r_high;
    assign out_multi = r_multi;
    assign out_zero  = r_zero;
    assign err_cnt   = r_err;

endmodule

// File: tb/tb_alu_const_operand_gen.sv
// Directed bench for alu_const_operand_gen: a 16-bit instance and an
// 8-bit/ERR_W=2 instance share stimulus and are checked against one model.
module tb_alu_const_operand_gen;

    localparam logic [7:0] DEF [16] = '{
        8'h01, 8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
        8'h66, 8'hAA, 8'h06, 8'h60, 8'h02, 8'h04, 8'h40, 8'h80
    };

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_sel;
    logic        req_fill;
    logic        req_high;
    logic        out_ready;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data;

    logic        req_ready, out_valid, out_high, out_multi, out_zero;
    logic [15:0] out_data;
    logic [7:0]  err_cnt;

    logic        s_req_ready, s_out_valid, s_out_high, s_out_multi, s_out_zero;
    logic [7:0]  s_out_data;
    logic [1:0]  s_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    alu_const_operand_gen #(
        .WIDTH(16), .LOW_W(8), .NUM_SEL(16), .ERR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_fill(req_fill), .req_high(req_high),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_high(out_high), .out_multi(out_multi), .out_zero(out_zero),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .err_cnt(err_cnt)
    );

    alu_const_operand_gen #(
        .WIDTH(8), .LOW_W(8), .NUM_SEL(16), .ERR_W(2)
    ) dut_small (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_sel(req_sel), .req_fill(req_fill), .req_high(req_high),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_high(s_out_high), .out_multi(s_out_multi), .out_zero(s_out_zero),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .err_cnt(s_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: one output slot plus a byte table.
    logic       m_valid;
    logic [15:0] m_data;
    logic       m_high, m_multi, m_zero;
    int         m_err;
    logic [7:0] m_table [16];

    function automatic logic [7:0] model_low(input logic [15:0] sel);
        logic [7:0] acc = 8'h00;
        for (int i = 0; i < 16; i++) if (sel[i]) acc = acc | m_table[i];
        return acc;
    endfunction

    function automatic int bits_set(input logic [15:0] sel);
        int n = 0;
        for (int i = 0; i < 16; i++) if (sel[i]) n++;
        return n;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 16'h0;
            m_high  <= 1'b0;
            m_multi <= 1'b0;
            m_zero  <= 1'b0;
            m_err   <= 0;
            for (int i = 0; i < 16; i++) m_table[i] <= DEF[i];
        end else begin
            if (req_valid && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                m_data  <= {(req_fill ? 8'hFF : 8'h00), model_low(req_sel)};
                m_high  <= req_high;
                m_multi <= (bits_set(req_sel) > 1);
                m_zero  <= (bits_set(req_sel) == 0);
                m_err   <= m_err + ((bits_set(req_sel) > 1) ? 1 : 0);
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            if (cfg_we) m_table[cfg_addr] <= cfg_data;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", 32'(req_ready), 32'(!m_valid || out_ready));
            chk("s_req_ready", 32'(s_req_ready), 32'(!m_valid || out_ready));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("s_out_valid", 32'(s_out_valid), 32'(m_valid));
            chk("err_cnt", 32'(err_cnt), 32'(sat(m_err, 255)));
            chk("s_err_cnt", 32'(s_err_cnt), 32'(sat(m_err, 3)));
            if (m_valid) begin
                chk("out_data", 32'(out_data), 32'(m_data));
                chk("s_out_data", 32'(s_out_data), 32'(m_data[7:0]));
                chk("out_high", 32'(out_high), 32'(m_high));
                chk("out_multi", 32'(out_multi), 32'(m_multi));
                chk("out_zero", 32'(out_zero), 32'(m_zero));
                chk("s_out_multi", 32'(s_out_multi), 32'(m_multi));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] sel, input logic f,
                         input logic h, input logic ordy);
        req_valid = v;
        req_sel   = sel;
        req_fill  = f;
        req_high  = h;
        out_ready = ordy;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = 4'd0;
        cfg_data = 8'h00;
        idle();

        look();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_flags", 32'({out_high, out_multi, out_zero}), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        tick();
        rst = 1'b0;
        look();
        chk("post_rst_ready", 32'(req_ready), 32'h1);

        tick();
        drive(1'b1, 16'h0100, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        look();
        chk("def66_valid", 32'(out_valid), 32'h1);
        chk("def66_data", 32'(out_data), 32'h0066);
        chk("def66_flags", 32'({out_multi, out_zero}), 32'h0);

        tick();
        drive(1'b1, 16'h0201, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        look();
        chk("fill_data", 32'(out_data), 32'hFFAB);
        chk("fill_small_data", 32'(s_out_data), 32'hAB);
        chk("fill_high", 32'(out_high), 32'h1);
        chk("fill_multi", 32'(out_multi), 32'h1);
        chk("fill_err", 32'(err_cnt), 32'h1);

        tick();
        drive(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 1'b0);
        cfg_we = 1'b1;
        cfg_addr = 4'd12;
        cfg_data = 8'h33;
        look();
        chk("stall1_ready", 32'(req_ready), 32'h0);
        chk("stall1_data", 32'(out_data), 32'h0008);
        tick();
        cfg_we = 1'b0;
        look();
        chk("stall2_data", 32'(out_data), 32'h0008);
        tick();
        look();
        chk("stall3_ready", 32'(req_ready), 32'h0);
        chk("stall3_data", 32'(out_data), 32'h0008);
        tick();
        out_ready = 1'b1;
        look();
        chk("release_ready", 32'(req_ready), 32'h1);
        chk("release_data", 32'(out_data), 32'h0008);
        tick();
        idle();
        look();
        chk("next_data", 32'(out_data), 32'h0010);
        chk("next_valid", 32'(out_valid), 32'h1);
        tick();
        look();
        chk("drained_valid", 32'(out_valid), 32'h0);

        tick();
        drive(1'b1, 16'h0008, 1'b0, 1'b0, 1'b1);
        cfg_we = 1'b1;
        cfg_addr = 4'd3;
        cfg_data = 8'h5A;
        tick();
        cfg_we = 1'b0;
        look();
        chk("rbw_old", 32'(out_data), 32'h0018);
        tick();
        idle();
        look();
        chk("rbw_new", 32'(out_data), 32'h005A);

        tick();
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        look();
        chk("zero_data", 32'(out_data), 32'h0000);
        chk("zero_flags", 32'({out_multi, out_zero}), 32'h1);

        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'h3000, 1'b0, 1'b0, 1'b1);
            tick();
        end
        idle();
        look();
        chk("sat_small_err", 32'(s_err_cnt), 32'h3);
        chk("sat_big_err", 32'(err_cnt), 32'h6);
        chk("stall_write_data", 32'(out_data), 32'h0037);

        tick();
        drive(1'b1, 16'h0008, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        look();
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        chk("pre_rst_data", 32'(out_data), 32'h005A);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_err", 32'(err_cnt), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(1'b1, 16'h0008, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        look();
        chk("table_restored", 32'(out_data), 32'h0018);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_const_operand_gen.md
Name: alu_const_operand_gen

Overview:
Registered constant-operand generator for ALU port A. A one-hot select picks one entry from a runtime-writable table of LOW_W-bit constants; the selected entries are wired-ORed. An optional upper-bit fill (the "0xFF00" operand form) and a high-bit flag can be added. The result goes to the ALU input stage through a valid/ready output register. It replaces the fixed combinational constant mux with one table-driven block.

Parameters:
WIDTH, 16, output operand width
LOW_W, 8, width of each table constant; occupies out_data[LOW_W-1:0]
NUM_SEL, 16, number of table entries / select lines
ERR_W, 8, width of saturating multi-hot error counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_sel  in  NUM_SEL  one-hot table select (OR semantics if not one-hot)
req_fill  in  1  force out_data[WIDTH-1:LOW_W] to all ones
req_high  in  1  high-bit flag, passed through to out_high
out_valid  out  1  output register holds a result
out_ready  in  1  consumer takes result when out_valid & out_ready
out_data  out  WIDTH  operand
out_high  out  1  registered req_high
out_multi  out  1  result came from a select with more than one bit set
out_zero  out  1  result came from an all-zero select
cfg_we  in  1  table write enable
cfg_addr  in  $clog2(NUM_SEL)  table write index
cfg_data  in  LOW_W  table write data
err_cnt  out  ERR_W  saturating count of accepted multi-hot requests

Behaviour:
- Reset (async, rst=1):
  - Table loads the package defaults.
  - out_valid=0, out_data=0, out_high=0, out_multi=0, out_zero=0, err_cnt=0.
  - req_ready=1 once rst deasserts.
- Reset mid-transfer: the pending output is discarded. There is no partial state.
- req_ready = !out_valid | out_ready (combinational). There is no combinational path from req_* to out_*.
- On acceptance, the result is registered at the next edge. Latency is exactly 1 cycle, and a full-throughput stream runs at 1 transfer per cycle.
- If the output is held (out_valid=1 and out_ready=0), all out_* stay stable and req_ready=0.
- If out_ready=1 and there is no new request, out_valid clears.
- Data computation:
  - low = OR over i of (req_sel[i] ? table[i] : 0).
  - out_data[LOW_W-1:0] = low.
  - out_data[WIDTH-1:LOW_W] = {WIDTH-LOW_W{req_fill}}.
  - If WIDTH==LOW_W, the fill has no effect.
- Flags:
  - out_zero = (req_sel==0).
  - out_multi = (popcount(req_sel)>1).
- err_cnt increments on every accepted multi-hot request and saturates at 2^ERR_W-1. It is never cleared except by rst.
- Table writes:
  - Write takes effect at the edge where cfg_we=1.
  - A request accepted in that same cycle uses the old value (read-before-write).
  - cfg_addr >= NUM_SEL is ignored, with no state change.
  - Writes are independent of the handshake and of stalls; a held output is not altered.
- Elaboration checks: LOW_W <= WIDTH and NUM_SEL >= 1, otherwise elaboration fails.

Decomposition:
- Package alu_const_pkg holds:
  - LOW_W_DEF and NUM_SEL_DEF.
  - Default table, index 0..15: 0x01,0x08,0x10,0x18,0x20,0x28,0x30,0x38,0x66,0xAA,0x06,0x60,0x02,0x04,0x40,0x80.
  - Select index name constants (SEL_1, SEL_8, SEL_66, ...).
- For NUM_SEL > 16, extra entries default to 0.
- One sub-module, alu_const_table: the writable register array with async-reset defaults and an OR-reduce read. The handshake and flag logic stay in the top level.

Test Plan:
- Reset defaults: after reset, req_sel=1<<8, req_fill=0, out_ready=1 -> next cycle out_valid=1, out_data=0x0066, out_multi=0, out_zero=0.
- Fill + OR: req_sel=(1<<0)|(1<<9), req_fill=1, req_high=1 -> out_data=0xFFAB, out_high=1, out_multi=1, err_cnt=1.
- Backpressure: out_ready=0 for 3 cycles with req_valid held (sel 1<<1, then 1<<2) -> req_ready=0, out_data stays 0x0008. On release, 0x0008 transfers, then 0x0010 follows the next cycle, with no loss or duplication.
- Write collision: cfg_we=1, cfg_addr=3, cfg_data=0x5A in the same cycle as accepting sel 1<<3 -> out_data=0x0018. The next request with sel 1<<3 -> 0x005A.
- Zero select and saturation: req_sel=0 -> out_data=0x0000, out_zero=1. With ERR_W=2, 5 multi-hot requests -> err_cnt=3.
- Async reset mid-stall: with out_valid=1 and out_ready=0, assert rst between clock edges -> out_valid=0 immediately. After release, table entry 3 reads 0x18 again.
